// File: rtl/popcnt_seq.sv
// popcnt_seq: buffers a byte stream, feeds one byte at a time to a popcount stage and
// reports the summed bit count per block. Define POPCNT_SEQ_TIMEOUT_EN for the WAIT timeout.
module popcnt_seq #(
    parameter int unsigned NBYTES      = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SUM_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             pc_start,
    output logic [7:0]       pc_a,
    input  logic [7:0]       pc_p,
    input  logic             pc_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StWait, StOut} state_e;

    // FIFO storage: {last, data}; pointers carry one extra wrap bit for full/empty.
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             fifo_empty, fifo_full;
    logic             push, pop;
    logic [8:0]       head;

    state_e           state_q, state_d;
    logic             pc_start_q, pc_start_d;
    logic [7:0]       pc_a_q, pc_a_d;
    logic             last_q, last_d;
    logic             first_wait_q, first_wait_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [7:0]       count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic [7:0]       out_count_q, out_count_d;
    logic             byte_done;
    logic [SUM_W-1:0] add;

`ifdef POPCNT_SEQ_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic             out_err_q, out_err_d;
`endif

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_start_d   = 1'b0;
        pc_a_d       = pc_a_q;
        last_d       = last_q;
        first_wait_d = first_wait_q;
        sum_d        = sum_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_sum_d    = out_sum_q;
        out_count_d  = out_count_q;
        pop          = 1'b0;
        byte_done    = 1'b0;
        add          = '0;
`ifdef POPCNT_SEQ_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        out_err_d    = out_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    pc_a_d     = head[7:0];
                    last_d     = head[8];
                    pc_start_d = 1'b1;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                first_wait_d = 1'b1;
                state_d      = StWait;
`ifdef POPCNT_SEQ_TIMEOUT_EN
                wait_cnt_d   = '0;
`endif
            end
            StWait: begin
                // A done still high from the previous operand is never taken.
                first_wait_d = 1'b0;
                if (!first_wait_q && pc_done) begin
                    byte_done = 1'b1;
                    add       = SUM_W'(pc_p);
                end
`ifdef POPCNT_SEQ_TIMEOUT_EN
                else if (wait_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    byte_done = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
                if (byte_done) begin
                    sum_d   = sum_q + add;
                    count_d = count_q + 8'd1;
                    if (last_q || count_d == 8'(NBYTES)) begin
                        state_d     = StOut;
                        out_valid_d = 1'b1;
                        out_sum_d   = sum_d;
                        out_count_d = count_d;
`ifdef POPCNT_SEQ_TIMEOUT_EN
                        out_err_d   = err_d;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    sum_d       = '0;
                    count_d     = '0;
`ifdef POPCNT_SEQ_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= StIdle;
            pc_start_q   <= 1'b0;
            pc_a_q       <= '0;
            last_q       <= 1'b0;
            first_wait_q <= 1'b0;
            sum_q        <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_count_q  <= '0;
`ifdef POPCNT_SEQ_TIMEOUT_EN
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
            out_err_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            pc_start_q   <= pc_start_d;
            pc_a_q       <= pc_a_d;
            last_q       <= last_d;
            first_wait_q <= first_wait_d;
            sum_q        <= sum_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            out_count_q  <= out_count_d;
`ifdef POPCNT_SEQ_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
            out_err_q    <= out_err_d;
`endif
        end
    end

    assign pc_start  = pc_start_q;
    assign pc_a      = pc_a_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
`ifdef POPCNT_SEQ_TIMEOUT_EN
    assign out_err   = out_err_q;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_popcnt_seq.sv
// Bench for popcnt_seq: popcount stage stub, block-level scoreboard model and directed tests.
module tb_popcnt_seq;
    localparam int unsigned NBYTES = 4;
    localparam int unsigned SUM_W  = 16;
    localparam int          DONE_DLY = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             pc_start;
    logic [7:0]       pc_a;
    logic [7:0]       pc_p;
    logic             pc_done;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_err;

    always #5 clk = ~clk;

    popcnt_seq #(
        .NBYTES      (NBYTES),
        .FIFO_DEPTH  (4),
        .SUM_W       (SUM_W),
        .TIMEOUT_CYC (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .pc_start  (pc_start),
        .pc_a      (pc_a),
        .pc_p      (pc_p),
        .pc_done   (pc_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_err   (out_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Popcount stage stub: pc_p shows junk for one cycle after start, the true count after that;
    // done pulses DONE_DLY cycles after start (or never for the dropped byte index).
    logic       stale = 1'b0;
    int         drop_idx = -1;
    logic [7:0] pc_p_r;
    logic       done_pulse;
    logic       busy;
    logic       drop_cur;
    logic [7:0] a_lat;
    int         dly;
    int         st_idx;

    always @(posedge clk) begin
        if (!rst_n) begin
            pc_p_r     <= 8'h00;
            done_pulse <= 1'b0;
            busy       <= 1'b0;
            drop_cur   <= 1'b0;
            a_lat      <= 8'h00;
            dly        <= 0;
            st_idx     <= 0;
        end else begin
            done_pulse <= 1'b0;
            if (pc_start) begin
                busy     <= 1'b1;
                dly      <= 1;
                a_lat    <= pc_a;
                pc_p_r   <= 8'h10;
                st_idx   <= st_idx + 1;
                drop_cur <= (st_idx == drop_idx);
            end else if (busy) begin
                dly <= dly + 1;
                if (dly == 1) pc_p_r <= 8'($countones(a_lat));
                if (dly == DONE_DLY && !drop_cur) begin
                    done_pulse <= 1'b1;
                    busy       <= 1'b0;
                end
            end
        end
    end

    assign pc_p    = pc_p_r;
    assign pc_done = stale ? 1'b1 : done_pulse;

    // Scoreboard: block results predicted from accepted bytes; checked on every negedge.
    logic [SUM_W-1:0] blk_sum;
    int               blk_cnt;
    logic             blk_err;
    int               acc_idx;
    logic [24:0]      exp_q[$];
    logic [7:0]       pca_q[$];
    logic             start_prev;
    logic             hold_prev;
    logic [24:0]      hold_val;
    int               n_results = 0;
    logic [15:0]      res_sum [32];
    logic [7:0]       res_cnt [32];
    logic             res_err [32];

    initial begin
        logic [24:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                pca_q.delete();
                blk_sum    = '0;
                blk_cnt    = 0;
                blk_err    = 1'b0;
                acc_idx    = 0;
                start_prev = 1'b0;
                hold_prev  = 1'b0;
            end else begin
                if (pc_start) begin
                    chk("pc_start_single", 32'(start_prev), 32'(0));
                    if (pca_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pc_start_unexpected: actual=start required=none at %0t", $time);
                    end else begin
                        chk("pc_a", 32'(pc_a), 32'(pca_q.pop_front()));
                    end
                end
                start_prev = pc_start;
                if (hold_prev) begin
                    chk("hold_valid", 32'(out_valid), 32'(1));
                    chk("hold_data", 32'({out_err, out_count, out_sum}), 32'(hold_val));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL result_unexpected: actual sum=%0d count=%0d required=none",
                                 out_sum, out_count);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_sum", 32'(out_sum), 32'(e[15:0]));
                        chk("out_count", 32'(out_count), 32'(e[23:16]));
                        chk("out_err", 32'(out_err), 32'(e[24]));
                    end
                    if (n_results < 32) begin
                        res_sum[n_results] = out_sum;
                        res_cnt[n_results] = out_count;
                        res_err[n_results] = out_err;
                    end
                    n_results++;
                end
                hold_prev = out_valid && !out_ready;
                hold_val  = {out_err, out_count, out_sum};
                if (in_valid && in_ready) begin
                    pca_q.push_back(in_data);
                    if (acc_idx == drop_idx) blk_err = 1'b1;
                    else blk_sum = blk_sum + SUM_W'($countones(in_data));
                    blk_cnt++;
                    acc_idx++;
                    if (in_last || blk_cnt == NBYTES) begin
                        exp_q.push_back({blk_err, 8'(blk_cnt), blk_sum});
                        blk_sum = '0;
                        blk_cnt = 0;
                        blk_err = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_accept: actual in_ready=0 required=1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_results(input int target);
        int k = 0;
        while (n_results < target && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("result_arrival", 32'(n_results), 32'(target));
    endtask

    task automatic chk_res(input string nm, input int i, input int s, input int c, input int er);
        chk({nm, "_sum"}, 32'(res_sum[i]), 32'(s));
        chk({nm, "_count"}, 32'(res_cnt[i]), 32'(c));
        chk({nm, "_err"}, 32'(res_err[i]), 32'(er));
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'(0));
        chk({nm, "_out_sum"}, 32'(out_sum), 32'(0));
        chk({nm, "_out_count"}, 32'(out_count), 32'(0));
        chk({nm, "_out_err"}, 32'(out_err), 32'(0));
        chk({nm, "_pc_start"}, 32'(pc_start), 32'(0));
        chk({nm, "_pc_a"}, 32'(pc_a), 32'(0));
        chk({nm, "_in_ready"}, 32'(in_ready), 32'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int target;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk);
        #1;

        // Full block of NBYTES.
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        send(8'h0F, 1'b0);
        send(8'h01, 1'b0);
        wait_results(1);
        chk_res("block4", 0, 13, 4, 0);

        // Early last, then a fresh one-byte block.
        send(8'hAA, 1'b0);
        send(8'h55, 1'b1);
        wait_results(2);
        chk_res("early_last", 1, 8, 2, 0);
        send(8'h03, 1'b1);
        wait_results(3);
        chk_res("fresh_block", 2, 2, 1, 0);

        // Output backpressure while the FIFO fills up.
        out_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h03, 1'b0);
        send(8'h07, 1'b0);
        send(8'h0F, 1'b0);
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'(1));
        repeat (4) send(8'hFF, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h80;
        in_last  = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("bp_fifo_full", 32'(in_ready), 32'(0));
            chk("bp_valid_held", 32'(out_valid), 32'(1));
        end
        out_ready = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("bp_ready_after_pop", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_res("bp_block", 3, 10, 4, 0);
        wait_results(6);
        chk_res("bp_queued", 4, 32, 4, 0);
        chk_res("bp_fifth", 5, 1, 1, 0);

        // Done held high throughout.
        stale = 1'b1;
        repeat (4) send(8'h07, 1'b0);
        wait_results(7);
        stale = 1'b0;
        chk_res("stale_done", 6, 12, 4, 0);

        // Reset during the second byte's WAIT with a third byte still queued.
        target = st_idx + 2;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h04, 1'b0);
        k = 0;
        while (st_idx < target && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("second_start_seen", 32'(st_idx), 32'(target));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("mid_reset");
        repeat (20) @(posedge clk);
        #1;
        chk("no_partial_result", 32'(n_results), 32'(7));
        repeat (4) send(8'h01, 1'b0);
        wait_results(8);
        chk_res("after_reset", 7, 4, 4, 0);

`ifdef POPCNT_SEQ_TIMEOUT_EN
        // Popcount stage never answers for the 0xFF byte.
        drop_idx = acc_idx + 1;
        send(8'h0F, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        wait_results(9);
        chk_res("timeout", 8, 6, 4, 1);
        drop_idx = -1;
        send(8'h03, 1'b1);
        wait_results(10);
        chk_res("after_timeout", 9, 2, 1, 0);
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/popcnt_seq.md
Name: popcnt_seq

Overview:
- Sequencer directly upstream of the byte popcount stage; accepts a byte stream over valid/ready into a small FIFO.
- Issues one start/operand per byte to the popcount stage and waits for its done.
- Accumulates per-byte counts into a block total; emits one result per block (NBYTES bytes or early in_last) over valid/ready.

Parameters:
- NBYTES, 4, maximum bytes per block (1..255).
- FIFO_DEPTH, 4, input FIFO entries (power of two, >=2).
- SUM_W, 16, width of block sum; must satisfy 2^SUM_W > 8*NBYTES, so no overflow is possible.
- TIMEOUT_CYC, 32, max WAIT cycles before timeout (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input byte valid
- in_ready  out  1  FIFO not full
- in_data  in  8  input byte
- in_last  in  1  byte closes current block early
- pc_start  out  1  start pulse to popcount stage
- pc_a  out  8  operand to popcount stage
- pc_p  in  8  popcount result
- pc_done  in  1  popcount complete
- out_valid  out  1  block result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  SUM_W  total set bits in block
- out_count  out  8  bytes in block (1..NBYTES)
- out_err  out  1  block had a timeout (0 when feature compiled out)

Behaviour:
- Reset (rst_n=0 at edge): FIFO emptied; FSM to IDLE; pc_start=0, pc_a=0, out_valid=0, out_sum=0, out_count=0, out_err=0, internal sum/byte count cleared. Reset mid-block discards everything; no partial result is emitted.
- FIFO:
  - Push when in_valid && in_ready; in_ready = !full (registered state, not dependent on in_valid).
  - Entry holds {in_last, in_data}.
  - Push and pop in the same cycle while full is illegal, since in_ready=0. While empty, push-then-pop takes effect next cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, LOAD, WAIT, OUT:
  - IDLE: if FIFO non-empty, pop head, latch byte into pc_a, latch last flag, go to LOAD.
  - LOAD: pc_start=1 for exactly this one cycle; pc_a stable. Go to WAIT.
  - WAIT:
    - pc_start=0, pc_a held.
    - pc_done ignored in the first WAIT cycle (stale-done guard); sampled from the second WAIT cycle on.
    - On pc_done=1: sum += zero-extended pc_p; count += 1.
    - If latched last or count+1==NBYTES, go to OUT with out_sum/out_count loaded; otherwise go to IDLE.
  - OUT:
    - out_valid=1; out_sum/out_count/out_err held stable until out_ready=1.
    - On handshake: out_valid drops next cycle; sum/count/err cleared; go to IDLE.
    - FIFO continues accepting input during WAIT/OUT.
- Latency: byte at FIFO head -> pc_start is 2 cycles (IDLE pop, LOAD). Final pc_done -> out_valid is 1 cycle.
- pc_p is used as-is; values >8 are not checked.

Optional Feature:
- Macro POPCNT_SEQ_TIMEOUT_EN.
- Defined: WAIT counts cycles. If pc_done is not seen within TIMEOUT_CYC cycles, that byte contributes 0 and the byte count still increments. out_err is set sticky for the block, and the FSM proceeds as if done arrived (IDLE or OUT).
- Undefined: WAIT blocks indefinitely; out_err is tied to 0; no timeout counter is instantiated.

Test Plan:
- Block sum: bytes 0xFF,0x00,0x0F,0x01, in_last=0; popcount model with done 9 cycles after start -> one result: out_sum=13, out_count=4, out_err=0.
- Early last: 0xAA, then 0x55 with in_last=1 -> out_sum=8, out_count=2. Next byte 0x03 starts a fresh block with sum reset.
- Backpressure:
  - out_ready=0 for 10 cycles after out_valid -> out_sum/out_count stable, out_valid held.
  - FIFO fills with 4 more bytes, then in_ready=0. The 5th byte is not accepted until a pop occurs.
- Stale done: pc_done held at 1 continuously. The first WAIT cycle is ignored and the result is taken on the second WAIT cycle. The sequence 0x07 x4 yields out_sum=12.
- Reset mid-WAIT: rst_n=0 for 1 cycle during the second byte's WAIT. Outputs return to 0, FIFO is empty, and no out_valid occurs. A subsequent block 0x01 x4 gives out_sum=4.
- Timeout (POPCNT_SEQ_TIMEOUT_EN, TIMEOUT_CYC=32): pc_done never asserted for byte 2 of 0x0F,0xFF,0x01,0x01. Result: out_sum=6, out_count=4, out_err=1. The following block has out_err=0.
